// File: rtl/l_class_oc_fifon.sv
// Guarded-method FIFO: DEPTH x WIDTH circular buffer with explicit occupancy count,
// synchronous clear and optional pipelined enqueue while full.
module l_class_oc_fifon #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter bit          PIPELINED = 1'b0,
  parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             enq__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [WIDTH-1:0] first,
  output logic             first__RDY,
  input  logic             clear__ENA,
  output logic             clear__RDY,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic empty, full, enq_fire, deq_fire;

  // Wrap by compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  assign enq__RDY   = PIPELINED ? (!full || deq__ENA) : !full;
  assign deq__RDY   = !empty;
  assign first__RDY = !empty;
  assign clear__RDY = 1'b1;
  assign first      = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Illegal fires are dropped here rather than corrupting state.
  assign deq_fire = deq__ENA && !empty && !clear__ENA;
  assign enq_fire = enq__ENA && enq__RDY && !clear__ENA && (!full || deq_fire);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear__ENA) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        mem_d[wr_ptr_q] = enq_v;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (deq_fire) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  enq_guard_a: assert property (@(posedge CLK) disable iff (RST) enq__ENA |-> enq__RDY);
  deq_guard_a: assert property (@(posedge CLK) disable iff (RST) deq__ENA |-> deq__RDY);

endmodule

// File: tb/tb_l_class_oc_fifon.sv
// Bench for l_class_oc_fifon: three configurations checked every cycle against
// a queue-based model, plus directed scenarios with literal expectations.
module tb_l_class_oc_fifon;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Instance 0: DEPTH 4 plain, 1: DEPTH 4 pipelined, 2: DEPTH 3 plain.
  int unsigned dep [3] = '{4, 4, 3};
  bit          pip [3] = '{1'b0, 1'b1, 1'b0};

  logic [2:0] enq_req, deq_req, clr_req;
  logic [2:0] enq_ena, deq_ena;
  logic [2:0] enq_rdy, deq_rdy, first_rdy, clear_rdy;
  logic [7:0] enq_v [3];
  logic [7:0] first [3];
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;

  // Producers and consumers honour the DUT guards.
  assign enq_ena = enq_req & enq_rdy;
  assign deq_ena = deq_req & deq_rdy;

  l_class_oc_fifon #(.WIDTH(8), .DEPTH(4), .PIPELINED(1'b0)) u_d4p0 (
    .CLK(CLK), .RST(RST), .enq__ENA(enq_ena[0]), .enq_v(enq_v[0]), .enq__RDY(enq_rdy[0]),
    .deq__ENA(deq_ena[0]), .deq__RDY(deq_rdy[0]), .first(first[0]), .first__RDY(first_rdy[0]),
    .clear__ENA(clr_req[0]), .clear__RDY(clear_rdy[0]), .count(cnt0)
  );
  l_class_oc_fifon #(.WIDTH(8), .DEPTH(4), .PIPELINED(1'b1)) u_d4p1 (
    .CLK(CLK), .RST(RST), .enq__ENA(enq_ena[1]), .enq_v(enq_v[1]), .enq__RDY(enq_rdy[1]),
    .deq__ENA(deq_ena[1]), .deq__RDY(deq_rdy[1]), .first(first[1]), .first__RDY(first_rdy[1]),
    .clear__ENA(clr_req[1]), .clear__RDY(clear_rdy[1]), .count(cnt1)
  );
  l_class_oc_fifon #(.WIDTH(8), .DEPTH(3), .PIPELINED(1'b0)) u_d3p0 (
    .CLK(CLK), .RST(RST), .enq__ENA(enq_ena[2]), .enq_v(enq_v[2]), .enq__RDY(enq_rdy[2]),
    .deq__ENA(deq_ena[2]), .deq__RDY(deq_rdy[2]), .first(first[2]), .first__RDY(first_rdy[2]),
    .clear__ENA(clr_req[2]), .clear__RDY(clear_rdy[2]), .count(cnt2)
  );

  // ---------------- model ----------------
  logic [7:0] q0[$], q1[$], q2[$];

  function automatic int mq_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] mq_front(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void mq_pop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void mq_push(input int i, input logic [7:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic void mq_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  function automatic bit exp_enq_rdy(input int i);
    return (mq_size(i) < int'(dep[i])) || (pip[i] && deq_req[i] && mq_size(i) > 0);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) mq_clear(i);
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit de, ee;
        de = deq_req[i] && mq_size(i) > 0;
        ee = enq_req[i] && exp_enq_rdy(i);
        if (clr_req[i]) begin
          mq_clear(i);
        end else begin
          if (de) mq_pop(i);
          if (ee) mq_push(i, enq_v[i]);
        end
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return {29'd0, cnt0};
      1:       return {29'd0, cnt1};
      default: return {30'd0, cnt2};
    endcase
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inst%0d count", i), cnt_of(i), mq_size(i));
      check($sformatf("inst%0d enq_rdy", i), {31'd0, enq_rdy[i]}, {31'd0, exp_enq_rdy(i)});
      check($sformatf("inst%0d deq_rdy", i), {31'd0, deq_rdy[i]}, {31'd0, mq_size(i) > 0});
      check($sformatf("inst%0d first_rdy", i), {31'd0, first_rdy[i]}, {31'd0, mq_size(i) > 0});
      check($sformatf("inst%0d clear_rdy", i), {31'd0, clear_rdy[i]}, 32'd1);
      if (mq_size(i) > 0) check($sformatf("inst%0d first", i), {24'd0, first[i]},
                                {24'd0, mq_front(i)});
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
    compare_all();
  endtask

  task automatic idle();
    enq_req = '0;
    deq_req = '0;
    clr_req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    for (int i = 0; i < 3; i++) enq_v[i] = 8'h00;
    tick();
    tick();
    RST = 1'b0;
    check("reset count", cnt_of(0), 32'd0);
    check("reset enq_rdy", {31'd0, enq_rdy[0]}, 32'd1);
    check("reset deq_rdy", {31'd0, deq_rdy[0]}, 32'd0);
    check("reset clear_rdy", {31'd0, clear_rdy[0]}, 32'd1);
    tick();

    // Fill and drain DEPTH 4.
    for (int k = 0; k < 4; k++) begin
      enq_req[0] = 1'b1;
      enq_v[0]   = 8'hA1 + 8'(k);
      tick();
    end
    idle();
    check("fill count", cnt_of(0), 32'd4);
    check("fill enq_rdy", {31'd0, enq_rdy[0]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("drain first", {24'd0, first[0]}, 32'hA1 + k);
      deq_req[0] = 1'b1;
      tick();
    end
    idle();
    check("drain first_rdy", {31'd0, first_rdy[0]}, 32'd0);

    // Asynchronous reset between edges with three entries.
    for (int k = 0; k < 3; k++) begin
      enq_req[0] = 1'b1;
      enq_v[0]   = 8'hB1 + 8'(k);
      tick();
    end
    idle();
    check("pre-reset count", cnt_of(0), 32'd3);
    #1 RST = 1'b1;
    #1;
    check("async count", cnt_of(0), 32'd0);
    check("async deq_rdy", {31'd0, deq_rdy[0]}, 32'd0);
    check("async enq_rdy", {31'd0, enq_rdy[0]}, 32'd1);
    check("async model", mq_size(0), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Alternating enq/deq on DEPTH 3, pointers wrap.
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        enq_req[2] = 1'b1;
        enq_v[2]   = 8'hC0 + 8'(k);
      end else begin
        check("wrap first", {24'd0, first[2]}, 32'hC0 + k - 1);
        deq_req[2] = 1'b1;
      end
      tick();
      idle();
      check("wrap count<=1", {31'd0, cnt_of(2) <= 1}, 32'd1);
    end
    check("wrap empty", cnt_of(2), 32'd0);

    // Full with simultaneous enq/deq: pipelined accepts, plain refuses.
    for (int k = 0; k < 4; k++) begin
      enq_req[0] = 1'b1; enq_v[0] = 8'hA1 + 8'(k);
      enq_req[1] = 1'b1; enq_v[1] = 8'hA1 + 8'(k);
      tick();
    end
    idle();
    enq_req[1:0] = 2'b11; deq_req[1:0] = 2'b11;
    enq_v[0] = 8'h55; enq_v[1] = 8'h55;
    #1;
    check("full p1 enq_rdy", {31'd0, enq_rdy[1]}, 32'd1);
    check("full p0 enq_rdy", {31'd0, enq_rdy[0]}, 32'd0);
    tick();
    idle();
    check("full p1 count", cnt_of(1), 32'd4);
    check("full p0 count", cnt_of(0), 32'd3);
    for (int k = 0; k < 4; k++) begin
      check("p1 order", {24'd0, first[1]}, (k == 3) ? 32'h55 : 32'hA2 + k);
      deq_req[1] = 1'b1;
      if (k < 3) begin
        check("p0 order", {24'd0, first[0]}, 32'hA2 + k);
        deq_req[0] = 1'b1;
      end
      tick();
      idle();
    end

    // Clear wins over a same-cycle enqueue.
    for (int k = 0; k < 2; k++) begin
      enq_req[0] = 1'b1; enq_v[0] = 8'hD1 + 8'(k);
      tick();
    end
    idle();
    check("clear pre count", cnt_of(0), 32'd2);
    clr_req[0] = 1'b1; enq_req[0] = 1'b1; enq_v[0] = 8'h77;
    tick();
    idle();
    check("clear count", cnt_of(0), 32'd0);
    check("clear first_rdy", {31'd0, first_rdy[0]}, 32'd0);
    enq_req[0] = 1'b1; enq_v[0] = 8'h88;
    tick();
    idle();
    check("post-clear first_rdy", {31'd0, first_rdy[0]}, 32'd1);
    check("post-clear first", {24'd0, first[0]}, 32'h88);
    deq_req[0] = 1'b1;
    tick();
    idle();

    // Random producer/consumer: fill-biased, then drain-biased, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        for (int i = 0; i < 3; i++) begin
          enq_req[i] = ($urandom_range(0, 3) < ((ph == 0) ? 3 : (ph == 1) ? 1 : 2));
          deq_req[i] = ($urandom_range(0, 3) < ((ph == 0) ? 1 : (ph == 1) ? 3 : 2));
          clr_req[i] = ($urandom_range(0, 63) == 0);
          enq_v[i]   = 8'($urandom_range(0, 255));
        end
        tick();
      end
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
